// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed request-to-response latency.
// One transaction is in flight at a time; misaligned accesses report an error.
module data_mem_responder #(
    parameter int NUM_WORDS = 16384,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               r_write;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [31:0]        r_mem [NUM_WORDS];

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_op_write;
    logic [31:0]        w_op_addr;
    logic [31:0]        w_op_wdata;
    logic               w_misaligned;
    logic [IDX_W-1:0]   w_index;
    logic               w_mem_we;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // With LATENCY=1 the memory operation happens on the acceptance edge itself,
    // before the request registers are loaded, so take the live inputs then.
    assign w_op_write   = (r_state == S_IDLE) ? req_write : r_write;
    assign w_op_addr    = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_op_wdata   = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_misaligned = (w_op_addr[1:0] != 2'b00);
    assign w_index      = IDX_W'(w_op_addr[31:2] % 30'(NUM_WORDS));
    assign w_mem_we     = w_enter_resp && w_op_write && !w_misaligned;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter_resp) begin
                if (w_misaligned) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end else if (w_op_write) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end else begin
                    resp_rdata <= r_mem[w_index];
                    resp_err   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[w_index] <= w_op_wdata;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 4, 1, 15) checked against
// an associative-array memory model with directed and randomized transactions.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic        busy       [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [int];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder #(.NUM_WORDS(16384), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    data_mem_responder #(.NUM_WORDS(64), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    data_mem_responder #(.NUM_WORDS(64), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .busy(busy[2])
    );

    function automatic int lat_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic int nw_of(input int k);
        return (k == 0) ? 16384 : 64;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+#1 with instance k idle. hold = cycles resp_ready stays low in RESP.
    task automatic txn(input int k, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold);
        int          cyc;
        int          key;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] held_rd;
        logic        held_err;
        key = k * (1 << 20) + int'((addr >> 2) % nw_of(k));
        if (addr[1:0] != 2'b00) begin
            exp_err = 1'b1;
            exp_rd  = '0;
        end else if (wr) begin
            exp_err = 1'b0;
            exp_rd  = '0;
            model[key] = wd;
        end else begin
            exp_err = 1'b0;
            exp_rd  = model.exists(key) ? model[key] : 32'h0;
        end

        check("req_ready before accept", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        req_write[k] = ~wr;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;

        cyc = 1;
        while (!resp_valid[k] && cyc < 40) begin
            check("busy while waiting", 32'(busy[k]), 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("latency L%0d", lat_of(k)), 32'(cyc), 32'(lat_of(k)));
        check("resp_rdata", resp_rdata[k], exp_rd);
        check("resp_err", 32'(resp_err[k]), 32'(exp_err));
        held_rd  = resp_rdata[k];
        held_err = resp_err[k];

        for (int h = 0; h < hold; h++) begin
            if (h == 2) begin
                req_valid[k] = 1'b1;
                req_write[k] = 1'b1;
                req_addr[k]  = addr & 32'hFFFF_FFFC;
                req_wdata[k] = ~wd;
            end else begin
                req_valid[k] = 1'b0;
            end
            @(posedge clk); #1;
            check("hold resp_valid", 32'(resp_valid[k]), 32'd1);
            check("hold resp_rdata", resp_rdata[k], held_rd);
            check("hold resp_err", 32'(resp_err[k]), 32'(held_err));
            check("hold req_ready", 32'(req_ready[k]), 32'd0);
        end
        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b1;
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        check("consume resp_valid", 32'(resp_valid[k]), 32'd0);
        check("consume req_ready", 32'(req_ready[k]), 32'd1);
        check("consume busy", 32'(busy[k]), 32'd0);
    endtask

    task automatic check_post_reset();
        for (int k = 0; k < 3; k++) begin
            check("reset req_ready", 32'(req_ready[k]), 32'd1);
            check("reset resp_valid", 32'(resp_valid[k]), 32'd0);
            check("reset busy", 32'(busy[k]), 32'd0);
            check("reset resp_rdata", resp_rdata[k], 32'h0);
            check("reset resp_err", 32'(resp_err[k]), 32'd0);
        end
    endtask

    initial begin
        int          idx;
        int          hi;
        int          mis;
        logic [31:0] a;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = '0;
            req_wdata[k]  = '0;
            resp_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_post_reset();

        // store then load, latency 4
        txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 0);

        // latency sweep after reset
        txn(1, 1'b0, 32'h0, 32'h0, 0);
        txn(2, 1'b0, 32'h0, 32'h0, 0);

        // backpressure: ten cycles of resp_ready low with a stray req_valid pulse
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 10);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 0);

        // misaligned store leaves memory untouched
        txn(0, 1'b1, 32'h0000_0022, 32'h1234_5678, 0);
        txn(0, 1'b0, 32'h0000_0020, 32'h0, 0);

        // upper address bits wrap
        txn(0, 1'b1, 32'h0001_0004, 32'hA5A5_A5A5, 0);
        txn(0, 1'b0, 32'h0000_0004, 32'h0, 0);

        // reset during WAIT aborts a pending store
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0008;
        req_wdata[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("mid-op busy", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model.delete();
        check_post_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("aborted resp_valid", 32'(resp_valid[0]), 32'd0);
        end
        txn(0, 1'b0, 32'h0000_0008, 32'h0, 0);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 0);

        // randomized traffic over a small index pool with aliased and misaligned addresses
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < ((k == 0) ? 40 : (k == 1) ? 20 : 6); n++) begin
                idx = int'($urandom_range(0, 7));
                hi  = int'($urandom_range(0, 3));
                mis = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
                a   = 32'(hi * nw_of(k) * 4 + idx * 4 + mis);
                txn(k, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be:
- NUM_WORDS, default 16384: storage depth in 32-bit words.
- LATENCY, default 4, legal range 1..15: cycles from request acceptance to response.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  requester presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  response reports a misaligned access.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-005 Acceptance SHALL occur at a rising edge where req_valid=1 and req_ready=1.
REQ-006 On acceptance the block SHALL register req_write, req_addr and req_wdata; later changes on the req_* inputs SHALL be ignored until the next acceptance.
REQ-007 On acceptance the FSM SHALL transition as follows:
- LATENCY=1: IDLE->RESP.
- Otherwise: IDLE->WAIT, with the down-counter loaded to LATENCY-2.
REQ-008 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL transition WAIT->RESP.
REQ-009 resp_valid SHALL first be high exactly LATENCY cycles after the acceptance edge.
REQ-010 The word index SHALL be addr[31:2] modulo NUM_WORDS; upper address bits SHALL wrap silently.
REQ-011 The memory operation SHALL execute at the edge that enters RESP:
- Load: resp_rdata <= mem[index].
- Store: mem[index] <= wdata, and resp_rdata <= 0.
REQ-012 If the registered addr[1:0] != 0, the block SHALL:
- perform no memory write;
- set resp_err=1 and resp_rdata=0;
- apply the same latency as a normal access.
REQ-013 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge where resp_ready=1; at that edge the FSM SHALL transition RESP->IDLE.
REQ-014 A new request SHALL NOT be accepted in the same cycle a response is consumed; the minimum issue interval SHALL be LATENCY+1 cycles.
REQ-015 resp_ready SHALL be ignored outside RESP.
REQ-016 req_valid SHALL be ignored outside IDLE.
REQ-017 A load to an index stored earlier SHALL return the stored value (read-after-write through memory).
REQ-018 busy SHALL equal (state != IDLE).

Reset
REQ-019 While reset=1 at a rising edge, the block SHALL:
- set the FSM to IDLE and the counter to 0;
- set resp_rdata=0 and resp_err=0;
- clear all memory words to 0.
REQ-020 Reset SHALL take priority over every other event, including acceptance and response consumption in the same cycle.
REQ-021 Reset asserted during WAIT or RESP SHALL abort the transaction:
- no pending store SHALL be committed;
- no response SHALL be issued.
REQ-022 In the first cycle after reset deasserts, the outputs SHALL be:
- req_ready=1;
- resp_valid=0;
- busy=0.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with LATENCY=4 unless stated:
- Store then load: store 0x0000_0010 <- 0xDEADBEEF, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0; resp_valid rises 4 cycles after each acceptance.
- Latency sweep: LATENCY=1 and LATENCY=15; load to 0x0 after reset -> resp_rdata=0; resp_valid exactly 1 and exactly 15 cycles after acceptance.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP -> resp_valid/resp_rdata stable, req_ready=0, a req_valid pulse is ignored; resp_ready=1 -> IDLE on the next edge.
- Misaligned: store to 0x0000_0022 <- 0x12345678 -> resp_err=1; load 0x20 -> 0x00000000, resp_err=0.
- Wrap-around: with NUM_WORDS=16384, store 0x0001_0004 <- 0xA5A5A5A5, then load 0x4 -> 0xA5A5A5A5.
- Reset mid-operation: accept a store to 0x8 <- 0xFFFFFFFF, assert reset during WAIT -> no resp_valid; load 0x8 -> 0x00000000.
